// File: rtl/float2fxp_pkg.sv
// Shared constants, input classes and saturation limits for the float-to-Qm.n converter.
package float2fxp_pkg;

  localparam int FP_EXP_W   = 8;
  localparam int FP_MAN_W   = 23;
  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_cls_e;

  // Largest magnitude an n-bit two's complement word can hold for the given sign.
  function automatic logic [32:0] sat_limit(input int unsigned n, input logic neg);
    logic [32:0] lim;
    lim = 33'd1 << (n - 32'd1);
    if (!neg) begin
      lim = lim - 33'd1;
    end else begin
      lim = lim;
    end
    return lim;
  endfunction

endpackage

// File: rtl/float2fxp_round_sat.sv
// Final stage: round the aligned magnitude, apply the sign and clamp into N bits.
// Round-to-nearest-even is selected by defining FLOAT2FXP_RNE_EN; otherwise truncation.
module float2fxp_round_sat
  import float2fxp_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         sign,
  input  logic [N-1:0] mag,
  input  logic         g,
  input  logic         s,
  input  logic         ovf,
  input  logic         nan,
  output logic [N-1:0] fxp,
  output logic         sat
);

  logic        rnd_up_s;
  logic [N:0]  rmag_s;
  logic [32:0] lim_pos_s;
  logic [32:0] lim_neg_s;

`ifdef FLOAT2FXP_RNE_EN
  assign rnd_up_s = g & (s | mag[0]);
`else
  // Guard and sticky are still produced upstream; truncation ignores them.
  assign rnd_up_s = 1'b0 & g & s;
`endif

  // One extra bit so a round-up carry out of the top is still seen by the clamp.
  assign rmag_s    = {1'b0, mag} + {{N{1'b0}}, rnd_up_s};
  assign lim_pos_s = sat_limit(N, 1'b0);
  assign lim_neg_s = sat_limit(N, 1'b1);

  // Select NaN / overflow / clamped / signed result.
  always_comb begin
    fxp = {N{1'b0}};
    sat = 1'b0;
    if (nan) begin
      fxp = {N{1'b0}};
      sat = 1'b1;
    end else if (ovf) begin
      fxp = sign ? N'(lim_neg_s) : N'(lim_pos_s);
      sat = 1'b1;
    end else if (sign) begin
      if (33'(rmag_s) > lim_neg_s) begin
        fxp = N'(lim_neg_s);
        sat = 1'b1;
      end else begin
        fxp = N'(-rmag_s);
        sat = 1'b0;
      end
    end else begin
      if (33'(rmag_s) > lim_pos_s) begin
        fxp = N'(lim_pos_s);
        sat = 1'b1;
      end else begin
        fxp = N'(rmag_s);
        sat = 1'b0;
      end
    end
  end

endmodule

// File: rtl/float2fxp_pipeline.sv
// Three-stage IEEE754 single to signed Qm.n converter with valid/ready, saturation and a
// saturation-event counter. Define FLOAT2FXP_RNE_EN for round-to-nearest-even.
module float2fxp_pipeline
  import float2fxp_pkg::*;
#(
  parameter int N     = 16,
  parameter int FRAC  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      fp_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [N-1:0]     fxp_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             sat_flag,
  output logic [CNT_W-1:0] sat_cnt
);

  logic en_s;

  fp_cls_e              cls_s;
  logic                 s1_valid_r;
  logic                 s1_sign_r;
  fp_cls_e              s1_cls_r;
  logic [FP_EXP_W-1:0]  s1_exp_r;
  logic [FP_MAN_W:0]    s1_sig_r;

  logic signed [9:0]    k_s;
  logic [49:0]          ext_s;
  logic [N-1:0]         mag_s;
  logic                 g_s;
  logic                 st_s;
  logic                 ovf_s;
  logic                 nan_s;

  logic                 s2_valid_r;
  logic                 s2_sign_r;
  logic [N-1:0]         s2_mag_r;
  logic                 s2_g_r;
  logic                 s2_s_r;
  logic                 s2_ovf_r;
  logic                 s2_nan_r;

  logic [N-1:0]         rs_fxp_s;
  logic                 rs_sat_s;

  // A stalled output freezes every stage so nothing is lost or duplicated.
  assign en_s      = !valid_out || ready_in;
  assign ready_out = en_s;

  // Classify the incoming word from its exponent and mantissa fields.
  always_comb begin
    cls_s = CLS_NORM;
    if (fp_in[30:23] == 8'd0) begin
      cls_s = CLS_ZERO;
    end else if (fp_in[30:23] == 8'(FP_EXP_MAX)) begin
      if (fp_in[22:0] != 23'd0) begin
        cls_s = CLS_NAN;
      end else begin
        cls_s = CLS_INF;
      end
    end else begin
      cls_s = CLS_NORM;
    end
  end

  // k is the bit position of the hidden one in output LSB units.
  assign k_s = {2'b00, s1_exp_r} - 10'(FP_BIAS) + 10'(FRAC);

  // Align the 24-bit significand to the output LSB, keeping guard and sticky.
  always_comb begin
    ext_s = 50'd0;
    mag_s = {N{1'b0}};
    g_s   = 1'b0;
    st_s  = 1'b0;
    ovf_s = 1'b0;
    nan_s = 1'b0;
    case (s1_cls_r)
      CLS_ZERO: begin
        mag_s = {N{1'b0}};
      end
      CLS_NAN: begin
        nan_s = 1'b1;
      end
      CLS_INF: begin
        ovf_s = 1'b1;
      end
      CLS_NORM: begin
        if (k_s >= $signed(10'(N))) begin
          ovf_s = 1'b1;
        end else if (k_s <= -10'sd2) begin
          st_s = 1'b1;
        end else if (k_s >= $signed(10'(FP_MAN_W))) begin
          mag_s = N'({8'd0, s1_sig_r} << $unsigned(k_s - $signed(10'(FP_MAN_W))));
        end else begin
          ext_s = {s1_sig_r, 26'd0} >> $unsigned($signed(10'(FP_MAN_W)) - k_s);
          mag_s = N'(ext_s[49:26]);
          g_s   = ext_s[25];
          st_s  = |ext_s[24:0];
        end
      end
      default: begin
        nan_s = 1'b0;
      end
    endcase
  end

  float2fxp_round_sat #(
    .N (N)
  ) u_round_sat (
    .sign (s2_sign_r),
    .mag  (s2_mag_r),
    .g    (s2_g_r),
    .s    (s2_s_r),
    .ovf  (s2_ovf_r),
    .nan  (s2_nan_r),
    .fxp  (rs_fxp_s),
    .sat  (rs_sat_s)
  );

  // Pipeline registers for all three stages; bubbles advance with valid low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_cls_r   <= CLS_ZERO;
      s1_exp_r   <= 8'd0;
      s1_sig_r   <= 24'd0;
      s2_valid_r <= 1'b0;
      s2_sign_r  <= 1'b0;
      s2_mag_r   <= {N{1'b0}};
      s2_g_r     <= 1'b0;
      s2_s_r     <= 1'b0;
      s2_ovf_r   <= 1'b0;
      s2_nan_r   <= 1'b0;
      valid_out  <= 1'b0;
      fxp_out    <= {N{1'b0}};
      sat_flag   <= 1'b0;
    end else if (en_s) begin
      s1_valid_r <= valid_in;
      s1_sign_r  <= fp_in[31];
      s1_cls_r   <= cls_s;
      s1_exp_r   <= fp_in[30:23];
      s1_sig_r   <= {1'b1, fp_in[22:0]};
      s2_valid_r <= s1_valid_r;
      s2_sign_r  <= s1_sign_r;
      s2_mag_r   <= mag_s;
      s2_g_r     <= g_s;
      s2_s_r     <= st_s;
      s2_ovf_r   <= ovf_s;
      s2_nan_r   <= nan_s;
      valid_out  <= s2_valid_r;
      fxp_out    <= rs_fxp_s;
      sat_flag   <= rs_sat_s;
    end else begin
      s1_valid_r <= s1_valid_r;
      s2_valid_r <= s2_valid_r;
      valid_out  <= valid_out;
    end
  end

  // Count delivered saturated results, sticking at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_cnt <= {CNT_W{1'b0}};
    end else if (valid_out && ready_in && sat_flag && (sat_cnt != {CNT_W{1'b1}})) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end else begin
      sat_cnt <= sat_cnt;
    end
  end

endmodule
